// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared constants for the nRisc 8-bit datapath.
// Data width and select encodings used by the operand/result muxes.
package nrisc_pkg;

  localparam int DATA_W = 8;

  localparam logic SEL_IN1 = 1'b0;
  localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux2_comb.sv
// mux2_comb: purely combinational WIDTH-wide 2:1 select.
// Feeds the output register stage of mux2_reg.
module mux2_comb
  import nrisc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = (sel_i == SEL_IN2) ? b_i : a_i;

endmodule

// File: rtl/mux2_reg.sv
// mux2_reg: registered 2:1 selector, one cycle latency.
// MUX_PARITY_EN adds an even-parity output tracking out_put.
module mux2_reg
  import nrisc_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             signalchoice,
  output logic [WIDTH-1:0] out_put,
`ifdef MUX_PARITY_EN
  output logic             out_parity,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_q;

  mux2_comb #(
    .WIDTH(WIDTH)
  ) u_sel (
    .a_i  (input1),
    .b_i  (input2),
    .sel_i(signalchoice),
    .y_o  (out_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= 1'b1;
    end
  end

  assign out_put   = out_q;
  assign out_valid = valid_q;

`ifdef MUX_PARITY_EN
  logic par_q;

  // Computed from the same select result so it always matches out_put.
  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= ^out_d;
  end

  assign out_parity = par_q;
`endif

endmodule

// File: tb/tb_mux2_reg.sv
// tb_mux2_reg: table-driven check of the registered 2:1 selector.
// Covers reset, select paths, full width, same-cycle change, mid-stream reset.
module tb_mux2_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] input1, input2;
  logic       signalchoice;
  logic [7:0] out_put;
  logic       out_valid;
`ifdef MUX_PARITY_EN
  logic       out_parity;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux2_reg #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input1      (input1),
    .input2      (input2),
    .signalchoice(signalchoice),
    .out_put     (out_put),
`ifdef MUX_PARITY_EN
    .out_parity  (out_parity),
`endif
    .out_valid   (out_valid)
  );

  typedef struct {
    logic       rst_n;
    logic       sel;
    logic [7:0] in1;
    logic [7:0] in2;
    logic [7:0] exp_out;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 8'h01, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 8'h00, 8'h01, 8'h01, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'hA5, 8'h5A, 8'hA5, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'hA5, 8'h5A, 8'h5A, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 8'hA5, 8'h3C, 8'hA5, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 8'hA5, 8'hC3, 8'hC3, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 8'h7E, 8'h00, 8'h7E, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 8'h7E, 8'h00, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h7E, 8'h00, 8'h7E, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 8'h7E, 8'hFF, 8'h7E, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 8'h00, 8'h80, 8'h80, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 8'h01, 8'hFE, 8'h01, 1'b1};

    rst_n        = 1'b0;
    signalchoice = 1'b0;
    input1       = 8'hFF;
    input2       = 8'hFF;

    for (int i = 0; i < 16; i++) begin
      rst_n        = vecs[i].rst_n;
      signalchoice = vecs[i].sel;
      input1       = vecs[i].in1;
      input2       = vecs[i].in2;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d out", i), 32'(out_put), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d valid", i), 32'(out_valid),
          32'(vecs[i].exp_valid));
`ifdef MUX_PARITY_EN
      chk($sformatf("vec%0d par", i), 32'(out_parity),
          32'(^vecs[i].exp_out));
`endif
    end

    // Inputs moving between edges must not reach the outputs.
    rst_n        = 1'b1;
    signalchoice = 1'b0;
    input1       = 8'h33;
    input2       = 8'hCC;
    @(posedge clk);
    #1;
    chk("hold pre", 32'(out_put), 32'h33);
    input1       = 8'h96;
    signalchoice = 1'b1;
    #2;
    chk("no comb path", 32'(out_put), 32'h33);
    input2 = 8'h0F;
    #1;
    chk("no comb path2", 32'(out_put), 32'h33);
    @(posedge clk);
    #1;
    chk("late change", 32'(out_put), 32'h0F);

    // Back-to-back selections, one per cycle.
    for (int k = 0; k < 4; k++) begin
      signalchoice = k[0];
      input1       = 8'(8'h10 + k);
      input2       = 8'(8'hE0 + k);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d", k), 32'(out_put),
          k[0] ? 32'(8'hE0 + k) : 32'(8'h10 + k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
